sw_alloc_rr: RTL and testbench

- Request-driven switch allocator for the 5-port router.
- Replaces fixed time-slot direction rotation: grants each output port to one input port per packet (wormhole lock).
- Per-output round-robin fairness among contending inputs.
- Drives crossbar select lines and per-input grants. Includes a lock timeout for stalled outputs.

---
 rtl/sw_alloc_rr.sv | 121 ++++++++++++
 tb/tb_sw_alloc_rr.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_alloc_rr.sv
// sw_alloc_rr: wormhole switch allocator with per-output round-robin arbitration and lock timeout
module sw_alloc_rr #(
  parameter int NP           = 5,
  parameter int SEL_W        = 3,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NP-1:0]         req,
  input  logic [NP*SEL_W-1:0]   req_dir,
  input  logic [NP-1:0]         tail,
  input  logic [NP-1:0]         out_ready,
  output logic [NP-1:0]         gnt,
  output logic [NP*SEL_W-1:0]   xbar_sel,
  output logic [NP-1:0]         out_valid,
  output logic [NP-1:0]         timeout
);
  localparam int CW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [SEL_W-1:0] NONE = '1;
  localparam logic [CW-1:0] STALL_MAX = CW'(LOCK_TIMEOUT - 1);

  logic [NP-1:0]    own_v_q, own_v_d, to_q, to_d, busy, xfer, xtail;
  logic [SEL_W-1:0] own_q [NP];
  logic [SEL_W-1:0] own_d [NP];
  logic [SEL_W-1:0] rr_q [NP];
  logic [SEL_W-1:0] rr_d [NP];
  logic [CW-1:0]    stall_q [NP];
  logic [CW-1:0]    stall_d [NP];
  logic             found;
  logic [SEL_W-1:0] win, idx;
  logic [SEL_W:0]   sum;

  always_comb begin
    busy  = '0;
    gnt   = '0;
    xfer  = '0;
    xtail = '0;
    for (int o = 0; o < NP; o++)
      for (int i = 0; i < NP; i++)
        if (own_v_q[o] && own_q[o] == SEL_W'(i)) begin
          busy[i] = 1'b1;
          if (req[i] && out_ready[o]) begin
            gnt[i]   = 1'b1;
            xfer[o]  = 1'b1;
            xtail[o] = tail[i];
          end
        end
  end

  assign out_valid = xfer;
  assign timeout   = to_q;

  always_comb begin
    own_v_d = own_v_q;
    own_d   = own_q;
    rr_d    = rr_q;
    stall_d = stall_q;
    to_d    = '0;
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    sum     = '0;
    for (int o = 0; o < NP; o++) begin
      found = 1'b0;
      win   = '0;
      // round-robin scan starting at rr_q, wrapping modulo NP
      for (int k = 0; k < NP; k++) begin
        sum = {1'b0, rr_q[o]} + (SEL_W+1)'(k);
        idx = (sum >= (SEL_W+1)'(NP)) ? SEL_W'(sum - (SEL_W+1)'(NP)) : SEL_W'(sum);
        if (!found && req[idx] && req_dir[idx*SEL_W +: SEL_W] == SEL_W'(o) && !busy[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (own_v_q[o]) begin
        if (xfer[o]) begin
          stall_d[o] = '0;
          if (xtail[o]) begin
            own_v_d[o] = 1'b0;
            own_d[o]   = NONE;
            rr_d[o]    = (own_q[o] == SEL_W'(NP-1)) ? '0 : own_q[o] + 1'b1;
          end
        end else if (LOCK_TIMEOUT > 0 && stall_q[o] == STALL_MAX) begin
          own_v_d[o] = 1'b0;
          own_d[o]   = NONE;
          rr_d[o]    = (own_q[o] == SEL_W'(NP-1)) ? '0 : own_q[o] + 1'b1;
          stall_d[o] = '0;
          to_d[o]    = 1'b1;
        end else begin
          stall_d[o] = stall_q[o] + 1'b1;
        end
      end else if (found) begin
        own_v_d[o] = 1'b1;
        own_d[o]   = win;
        stall_d[o] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_v_q <= '0;
      to_q    <= '0;
      for (int o = 0; o < NP; o++) begin
        own_q[o]   <= NONE;
        rr_q[o]    <= '0;
        stall_q[o] <= '0;
      end
    end else begin
      own_v_q <= own_v_d;
      to_q    <= to_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_sel
    assign xbar_sel[g*SEL_W +: SEL_W] = own_q[g];
  end
endmodule

// File: tb/tb_sw_alloc_rr.sv
// tb_sw_alloc_rr: directed and randomized checks of sw_alloc_rr against a behavioural allocator model
module tb_sw_alloc_rr;
  localparam int LT = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  req = '0, tail = '0, out_ready = '0;
  logic [14:0] req_dir = '0;
  logic [4:0]  gnt, out_valid, timeout;
  logic [14:0] xbar_sel;

  int total = 0, bad = 0;
  int m_own[5], m_rr[5], m_st[5];
  logic [4:0] m_to, mg, mv;
  int left[5], dir[5], badt[5];
  int storm, so, g0, s0, t0;

  sw_alloc_rr dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .tail(tail),
    .out_ready(out_ready), .gnt(gnt), .xbar_sel(xbar_sel),
    .out_valid(out_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int rdir(int i);
    return int'(req_dir[i*3 +: 3]);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int o = 0; o < 5; o++) begin
      m_own[o] = -1;
      m_rr[o]  = 0;
      m_st[o]  = 0;
    end
    m_to = '0;
  endtask

  function automatic logic [14:0] m_sel();
    logic [14:0] s;
    for (int o = 0; o < 5; o++) s[o*3 +: 3] = (m_own[o] < 0) ? 3'd7 : 3'(m_own[o]);
    return s;
  endfunction

  task automatic m_eval();
    mg = '0;
    mv = '0;
    for (int o = 0; o < 5; o++)
      if (m_own[o] >= 0 && req[m_own[o]] && out_ready[o]) begin
        mg[m_own[o]] = 1'b1;
        mv[o] = 1'b1;
      end
  endtask

  // next model state from the inputs of the cycle just checked
  task automatic m_step();
    int n_own[5], n_rr[5], n_st[5];
    logic [4:0] n_to, held;
    int i;
    held = '0;
    for (int o = 0; o < 5; o++) if (m_own[o] >= 0) held[m_own[o]] = 1'b1;
    for (int o = 0; o < 5; o++) begin
      n_own[o] = m_own[o];
      n_rr[o]  = m_rr[o];
      n_st[o]  = m_st[o];
      n_to[o]  = 1'b0;
      if (m_own[o] >= 0) begin
        i = m_own[o];
        if (mv[o]) begin
          n_st[o] = 0;
          if (tail[i]) begin
            n_own[o] = -1;
            n_rr[o]  = (i + 1) % 5;
          end
        end else if (m_st[o] + 1 == LT) begin
          n_own[o] = -1;
          n_rr[o]  = (i + 1) % 5;
          n_st[o]  = 0;
          n_to[o]  = 1'b1;
        end else begin
          n_st[o] = m_st[o] + 1;
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          i = (m_rr[o] + k) % 5;
          if (n_own[o] < 0 && req[i] && rdir(i) == o && !held[i]) begin
            n_own[o] = i;
            n_st[o]  = 0;
          end
        end
      end
    end
    m_own = n_own;
    m_rr  = n_rr;
    m_st  = n_st;
    m_to  = n_to;
  endtask

  task automatic cyc();
    @(negedge clk);
    m_eval();
    chk("gnt", gnt, mg);
    chk("out_valid", out_valid, mv);
    chk("xbar_sel", xbar_sel, m_sel());
    chk("timeout", timeout, m_to);
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(int i, logic r, int d, logic t);
    req[i] = r;
    req_dir[i*3 +: 3] = 3'(d);
    tail[i] = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '1;
    req_dir = '0;
    tail = '0;
    out_ready = '1;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset xbar_sel", xbar_sel, 15'h7fff);
    chk("reset gnt", gnt, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset timeout", timeout, 0);
    req = '0;
    rst = 1'b0;
    mg = '0;
  endtask

  initial begin
    // 3-flit packet, input 1 to East
    do_reset();
    setp(1, 1, 3, 0);
    #1 chk("t1 sel c0", xbar_sel[11:9], 7);
    cyc();
    #1 chk("t1 sel c1", xbar_sel[11:9], 1);
    chk("t1 gnt c1", gnt, 5'b00010);
    cyc();
    #1 chk("t1 gnt c2", gnt, 5'b00010);
    cyc();
    setp(1, 1, 3, 1);
    #1 chk("t1 gnt c3", gnt, 5'b00010);
    cyc();
    setp(1, 0, 3, 0);
    #1 chk("t1 sel c4", xbar_sel[11:9], 7);
    chk("t1 gnt c4", gnt, 0);
    chk("t1 rr east", m_rr[3], 2);
    cyc();

    // round-robin among single-flit senders to Local
    do_reset();
    begin
      int e[10] = '{1, 0, 4, 0, 16, 0, 1, 0, 4, 0};
      setp(0, 1, 0, 1);
      setp(2, 1, 0, 1);
      setp(4, 1, 0, 1);
      cyc();
      for (int c = 0; c < 10; c++) begin
        #1 chk($sformatf("t2 gnt c%0d", c + 1), gnt, e[c]);
        cyc();
      end
    end

    // stalled North lock times out, contender takes over
    do_reset();
    out_ready = 5'b11101;
    setp(3, 1, 1, 0);
    setp(4, 1, 1, 0);
    cyc();
    for (int c = 1; c <= 16; c++) begin
      #1 chk("t3 gnt stall", gnt, 0);
      if (c == 16) chk("t3 timeout c16", timeout, 0);
      cyc();
    end
    #1 chk("t3 timeout c17", timeout, 5'b00010);
    chk("t3 sel c17", xbar_sel[5:3], 7);
    cyc();
    #1 chk("t3 sel c18", xbar_sel[5:3], 4);
    chk("t3 timeout c18", timeout, 0);
    cyc();

    // five disjoint input->output pairs in parallel
    do_reset();
    for (int i = 0; i < 5; i++) setp(i, 1, (i + 1) % 5, 0);
    cyc();
    #1 chk("t4 gnt", gnt, 5'b11111);
    chk("t4 sel", xbar_sel, 15'b011_010_001_000_100);
    cyc();
    cyc();

    // reset in the middle of a West packet
    do_reset();
    setp(1, 1, 4, 1);
    cyc();
    cyc();
    setp(1, 0, 4, 0);
    setp(2, 1, 4, 0);
    cyc();
    cyc();
    cyc();
    #1 chk("t5 sel before", xbar_sel[14:12], 2);
    chk("t5 rr before", m_rr[4], 2);
    rst = 1'b1;
    #1 chk("t5 sel in reset", xbar_sel, 15'h7fff);
    chk("t5 gnt in reset", gnt, 0);
    m_reset();
    setp(0, 1, 4, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    #1 chk("t5 realloc", xbar_sel[14:12], 0);
    cyc();

    // illegal destination is never served
    do_reset();
    setp(0, 1, 6, 0);
    g0 = 0; s0 = 0; t0 = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (gnt[0]) g0++;
      if (xbar_sel != 15'h7fff) s0++;
      if (timeout != 0) t0++;
    end
    chk("t6 gnt count", g0, 0);
    chk("t6 owned count", s0, 0);
    chk("t6 timeout count", t0, 0);

    // randomized traffic
    do_reset();
    storm = 0;
    so = 0;
    for (int i = 0; i < 5; i++) begin
      left[i] = 0;
      dir[i] = 0;
      badt[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (mg[i] && left[i] > 0) left[i]--;
        if (dir[i] >= 5 && left[i] > 0) begin
          if (badt[i] == 0) left[i] = 0;
          else badt[i]--;
        end
        if (left[i] == 0 && $urandom_range(0, 3) == 0) begin
          left[i] = $urandom_range(1, 4);
          dir[i]  = ($urandom_range(0, 11) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
          badt[i] = $urandom_range(2, 12);
        end
        setp(i, left[i] > 0 && $urandom_range(0, 7) != 0, dir[i], left[i] == 1);
      end
      if (storm > 0) storm--;
      else if ($urandom_range(0, 59) == 0) begin
        storm = $urandom_range(16, 24);
        so = $urandom_range(0, 4);
      end
      for (int o = 0; o < 5; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
      if (storm > 0) out_ready[so] = 1'b0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
